// File: rtl/pacman_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pacman_irq_ctrl
// Description : Pac-Man style interrupt controller. Latches the IM2 vector
//               and interrupt enable from CPU writes, raises a level-held
//               maskable interrupt on the vblank rising edge, presents the
//               vector during the acknowledge cycle, and runs a kickable
//               watchdog that emits a one-cycle active-low reset pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pacman_irq_ctrl #(
  parameter logic [23:0] WDOG_LIMIT = 24'd8000000,
  parameter bit          WDOG_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_A,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic        vblank,
  output logic        cpu_int_n,
  output logic        vec_valid,
  output logic [7:0]  vec_data,
  output logic        wdog_rst_n
);

  localparam logic [15:0] INT_EN_ADDR = 16'h5000;
  localparam logic [15:0] WDOG_ADDR   = 16'h50C0;
  localparam logic [7:0]  VEC_PORT    = 8'h00;

  // Raw bus strobes decoded from the active-low CPU control lines
  logic mem_wr;
  logic io_wr;
  logic inta;

  // One-cycle history of each strobe and of vblank, for edge detection
  logic mem_wr_q;
  logic io_wr_q;
  logic inta_q;
  logic vblank_q;

  // Architectural state
  logic       int_en_q,  int_en_d;
  logic [7:0] vector_q,  vector_d;
  logic       pending_q, pending_d;
  logic       cpu_int_n_q;

  // Single-cycle events
  logic mem_wr_evt;
  logic io_wr_evt;
  logic inta_evt;
  logic vblank_rise;
  logic en_wr;
  logic vec_wr;
  logic kick;

  assign mem_wr = ~cpu_mreq_n & ~cpu_wr_n;
  assign io_wr  = ~cpu_iorq_n & ~cpu_wr_n & cpu_m1_n;
  assign inta   = ~cpu_iorq_n & ~cpu_m1_n;

  // A strobe held for several cycles must act only once, so only the
  // transition from inactive to active is treated as an event.
  assign mem_wr_evt  = mem_wr & ~mem_wr_q;
  assign io_wr_evt   = io_wr  & ~io_wr_q;
  assign inta_evt    = inta   & ~inta_q;
  assign vblank_rise = vblank & ~vblank_q;

  assign en_wr  = mem_wr_evt & (cpu_A == INT_EN_ADDR);
  assign vec_wr = io_wr_evt  & (cpu_A[7:0] == VEC_PORT);
  assign kick   = mem_wr_evt & (cpu_A == WDOG_ADDR);

  // Next-state for enable, vector and pending request
  always_comb begin
    int_en_d  = int_en_q;
    vector_d  = vector_q;
    pending_d = pending_q;
    if (en_wr) begin
      int_en_d = cpu_dout[0];
    end
    if (vec_wr) begin
      vector_d = cpu_dout;
    end
    // Disabling wins outright; a new vblank edge beats a simultaneous
    // acknowledge so the second frame's request is not lost. The enable
    // used for the vblank test includes a write landing this same cycle.
    if (en_wr && !cpu_dout[0]) begin
      pending_d = 1'b0;
    end else if (vblank_rise && int_en_d) begin
      pending_d = 1'b1;
    end else if (inta_evt) begin
      pending_d = 1'b0;
    end
  end

  // Edge history, interrupt state and the registered request line
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_wr_q    <= 1'b0;
      io_wr_q     <= 1'b0;
      inta_q      <= 1'b0;
      vblank_q    <= 1'b0;
      int_en_q    <= 1'b0;
      vector_q    <= 8'h00;
      pending_q   <= 1'b0;
      cpu_int_n_q <= 1'b1;
    end else begin
      mem_wr_q    <= mem_wr;
      io_wr_q     <= io_wr;
      inta_q      <= inta;
      vblank_q    <= vblank;
      int_en_q    <= int_en_d;
      vector_q    <= vector_d;
      pending_q   <= pending_d;
      cpu_int_n_q <= ~pending_q;
    end
  end

  assign cpu_int_n = cpu_int_n_q;

  // The vector is only driven during the acknowledge cycle so the top-level
  // data mux can give it priority without extra qualification.
  assign vec_valid = inta;
  assign vec_data  = inta ? vector_q : 8'h00;

  generate
    if (WDOG_EN) begin : g_wdog
      localparam logic [23:0] WDOG_TERM = WDOG_LIMIT - 24'd1;

      logic [23:0] wdog_cnt_q;
      logic        wdog_rst_n_q;

      // Free-running watchdog; a kick takes precedence over expiry
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          wdog_cnt_q   <= 24'd0;
          wdog_rst_n_q <= 1'b1;
        end else if (kick) begin
          wdog_cnt_q   <= 24'd0;
          wdog_rst_n_q <= 1'b1;
        end else if (wdog_cnt_q == WDOG_TERM) begin
          wdog_cnt_q   <= 24'd0;
          wdog_rst_n_q <= 1'b0;
        end else begin
          wdog_cnt_q   <= wdog_cnt_q + 24'd1;
          wdog_rst_n_q <= 1'b1;
        end
      end

      assign wdog_rst_n = wdog_rst_n_q;
    end else begin : g_no_wdog
      assign wdog_rst_n = 1'b1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pacman_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pacman_irq_ctrl
// Description : Scoreboard bench for pacman_irq_ctrl. Directed stimulus
//               pushes hand-computed expected output events (with the cycle
//               they must appear in); a negedge monitor pops and compares
//               each time the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pacman_irq_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_A;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_wr_n, cpu_m1_n;
  logic        vblank;

  logic        int_n, vv, wd;
  logic [7:0]  vd;
  logic        dis_int_n, dis_vv, dis_wd;
  logic [7:0]  dis_vd;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   dis_low = 0;
  bit   mon_en = 1'b0;
  exp_t q_int[$];
  exp_t q_vec[$];
  exp_t q_wd[$];

  pacman_irq_ctrl #(.WDOG_LIMIT(24'd16), .WDOG_EN(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .cpu_A(cpu_A), .cpu_dout(cpu_dout),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_wr_n(cpu_wr_n),
    .cpu_m1_n(cpu_m1_n), .vblank(vblank), .cpu_int_n(int_n),
    .vec_valid(vv), .vec_data(vd), .wdog_rst_n(wd)
  );

  pacman_irq_ctrl #(.WDOG_LIMIT(24'd16), .WDOG_EN(1'b0)) u_dis (
    .clk(clk), .reset_n(reset_n), .cpu_A(cpu_A), .cpu_dout(cpu_dout),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_wr_n(cpu_wr_n),
    .cpu_m1_n(cpu_m1_n), .vblank(vblank), .cpu_int_n(dis_int_n),
    .vec_valid(dis_vv), .vec_data(dis_vd), .wdog_rst_n(dis_wd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_evt(input int kind, input logic [7:0] val, input string name);
    exp_t e;
    bit   have;
    have = 1'b0;
    e.cyc = 0;
    e.val = 8'h00;
    case (kind)
      0: if (q_int.size() > 0) begin e = q_int.pop_front(); have = 1'b1; end
      1: if (q_vec.size() > 0) begin e = q_vec.pop_front(); have = 1'b1; end
      default: if (q_wd.size() > 0) begin e = q_wd.pop_front(); have = 1'b1; end
    endcase
    vectors++;
    if (!have) begin
      miscompares++;
      $display("FAIL %s: unexpected event at cycle %0d value %0h, none expected", name, cyc, val);
    end else if (e.cyc != cyc || e.val !== val) begin
      miscompares++;
      $display("FAIL %s: got cycle %0d value %0h, expected cycle %0d value %0h",
               name, cyc, val, e.cyc, e.val);
    end
  endtask

  task automatic push_int(input int at, input logic v);
    exp_t e;
    e.cyc = at;
    e.val = {7'b0, v};
    q_int.push_back(e);
  endtask

  task automatic push_vec(input int at, input logic [7:0] v);
    exp_t e;
    e.cyc = at;
    e.val = v;
    q_vec.push_back(e);
  endtask

  task automatic push_wd(input int at);
    exp_t e;
    e.cyc = at;
    e.val = 8'h00;
    q_wd.push_back(e);
  endtask

  // Monitor: turns output changes into events and scores them
  logic prev_int = 1'b1;
  logic prev_vv  = 1'b0;
  logic prev_wd  = 1'b1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (int_n !== prev_int) check_evt(0, {7'b0, int_n}, "cpu_int_n");
      if (vv === 1'b1 && prev_vv !== 1'b1) check_evt(1, vd, "vec_data");
      if (vv !== 1'b1) cmp("vec_data_idle", {24'b0, vd}, 32'h0);
      if (wd === 1'b0 && prev_wd === 1'b1) check_evt(2, 8'h00, "wdog_rst_n");
      if (wd === 1'b0 && prev_wd === 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL wdog_width: got low for 2+ cycles at cycle %0d, required 1", cyc);
      end
      if (dis_wd !== 1'b1) dis_low++;
      prev_int <= int_n;
      prev_vv  <= vv;
      prev_wd  <= wd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_A = a; cpu_dout = d; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    tick();
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_A = a; cpu_dout = d; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0; cpu_m1_n = 1'b1;
    tick();
    cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  task automatic mem_rd(input logic [15:0] a);
    cpu_A = a; cpu_dout = 8'h00; cpu_mreq_n = 1'b0;
    tick();
    cpu_mreq_n = 1'b1;
  endtask

  task automatic io_rd(input logic [15:0] a);
    cpu_A = a; cpu_dout = 8'h55; cpu_iorq_n = 1'b0;
    tick();
    cpu_iorq_n = 1'b1;
  endtask

  task automatic inta(input int n, input logic [7:0] exp_vec);
    push_vec(cyc, exp_vec);
    cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0;
    repeat (n) tick();
    cpu_iorq_n = 1'b1; cpu_m1_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int   r, r2, x, d, k, c;
    exp_t t;
    reset_n = 1'b0; cpu_A = 16'h0000; cpu_dout = 8'h00;
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
    vblank = 1'b0;

    // Reset state
    repeat (3) tick();
    mon_en = 1'b1;
    @(negedge clk);
    cmp("reset_cpu_int_n", {31'b0, int_n}, 32'h1);
    cmp("reset_vec_valid", {31'b0, vv}, 32'h0);
    cmp("reset_vec_data", {24'b0, vd}, 32'h0);
    cmp("reset_wdog_rst_n", {31'b0, wd}, 32'h1);
    tick();

    // Release; no kicks during the interrupt tests, so pulses every 16
    reset_n = 1'b1;
    r = cyc;
    for (int i = 1; i <= 20; i++) push_wd(r + 16 * i);

    // Basic flow: vector via IO port 0 (upper address ignored), enable, vblank
    io_wr(16'hAB00, 8'hCF);
    mem_wr(16'h5000, 8'h01);
    vblank = 1'b1; push_int(cyc + 2, 1'b0);
    repeat (4) tick();
    vblank = 1'b0;
    repeat (2) tick();
    push_int(cyc + 2, 1'b1);
    inta(1, 8'hCF);
    repeat (3) tick();

    // Edge while disabled is dropped; enabling with vblank steady does nothing
    mem_wr(16'h5000, 8'h00);
    vblank = 1'b1;
    repeat (3) tick();
    mem_wr(16'h5000, 8'h01);
    repeat (3) tick();
    vblank = 1'b0;
    repeat (2) tick();

    // Accesses that must not alter state
    mem_wr(16'h5001, 8'h00);
    io_wr(16'h0001, 8'h55);
    mem_rd(16'h5000);
    io_rd(16'h0000);
    repeat (2) tick();

    // New vblank edge coinciding with acknowledge keeps the request
    vblank = 1'b1; push_int(cyc + 2, 1'b0);
    repeat (3) tick();
    vblank = 1'b0;
    repeat (2) tick();
    push_vec(cyc, 8'hCF);
    cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0; vblank = 1'b1;
    tick();
    cpu_iorq_n = 1'b1; cpu_m1_n = 1'b1;
    repeat (2) tick();
    vblank = 1'b0;
    repeat (2) tick();
    push_int(cyc + 2, 1'b1);
    inta(1, 8'hCF);
    repeat (3) tick();

    // Held acknowledge acts once: vblank during its second cycle re-arms
    vblank = 1'b1; push_int(cyc + 2, 1'b0);
    repeat (3) tick();
    vblank = 1'b0;
    repeat (2) tick();
    d = cyc;
    push_vec(d, 8'hCF); push_int(d + 2, 1'b1); push_int(d + 3, 1'b0);
    cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0;
    tick();
    vblank = 1'b1;
    repeat (2) tick();
    cpu_iorq_n = 1'b1; cpu_m1_n = 1'b1;
    tick();
    vblank = 1'b0;
    repeat (2) tick();
    push_int(cyc + 2, 1'b1);
    inta(1, 8'hCF);
    repeat (3) tick();

    // Disable while pending withdraws the request
    vblank = 1'b1; push_int(cyc + 2, 1'b0);
    repeat (3) tick();
    push_int(cyc + 2, 1'b1);
    mem_wr(16'h5000, 8'h00);
    vblank = 1'b0;
    repeat (3) tick();

    // Enable written in the same cycle as the vblank edge takes effect
    c = cyc;
    push_int(c + 2, 1'b0);
    cpu_A = 16'h5000; cpu_dout = 8'h01; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; vblank = 1'b1;
    tick();
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    repeat (3) tick();

    // Disable beats a simultaneous vblank edge; the edge is not queued
    vblank = 1'b0;
    repeat (2) tick();
    c = cyc;
    push_int(c + 2, 1'b1);
    cpu_A = 16'h5000; cpu_dout = 8'h00; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; vblank = 1'b1;
    tick();
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    repeat (3) tick();
    mem_wr(16'h5000, 8'h01);
    repeat (3) tick();

    // Reset with a request pending and watchdog count at 12
    vblank = 1'b0;
    tick();
    vblank = 1'b1; push_int(cyc + 2, 1'b0);
    repeat (3) tick();
    vblank = 1'b0;
    x = cyc + 1;
    while (((x - r) % 16) != 12) x++;
    while (cyc < x) tick();
    reset_n = 1'b0;
    while (q_wd.size() > 0) begin
      t = q_wd[q_wd.size() - 1];
      if (t.cyc <= x) break;
      void'(q_wd.pop_back());
    end
    push_int(x + 1, 1'b1);
    repeat (2) tick();
    reset_n = 1'b1;
    r2 = cyc;

    // Vector was cleared by reset; watchdog restarts from zero
    push_wd(r2 + 16); push_wd(r2 + 32); push_wd(r2 + 48);
    inta(1, 8'h00);
    while (cyc < r2 + 50) tick();

    // Regular kicks every 10 cycles: no pulse
    for (int i = 0; i < 6; i++) begin
      mem_wr(16'h50C0, 8'(i * 37));
      repeat (9) tick();
    end

    // Kick landing on the terminal count suppresses the pulse
    k = cyc;
    mem_wr(16'h50C0, 8'hA5);
    while (cyc < k + 16) tick();
    mem_wr(16'h50C0, 8'h00);
    push_wd(k + 33);
    while (cyc < k + 20) tick();
    io_wr(16'h50C0, 8'h11);
    while (cyc < k + 24) tick();
    mem_rd(16'h50C0);
    while (cyc < k + 40) tick();

    repeat (3) tick();
    cmp("wdog_disabled_low_cycles", dis_low, 0);
    cmp("int_events_outstanding", q_int.size(), 0);
    cmp("vec_events_outstanding", q_vec.size(), 0);
    cmp("wdog_events_outstanding", q_wd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
